// File: rtl/commit_trace_checker.sv
// N-lane commit-trace comparator: queues writeback register writes and checks them against a golden stream.
// Build option TRACE_CMP_SKIP_EN excludes the exception-entry PC window [SKIP_BASE, SKIP_BASE+SKIP_LEN) from comparison.
module commit_trace_checker #(
    parameter int          LANES     = 2,
    parameter int          DEPTH     = 16,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] END_PC    = 32'hbfc00100,
    parameter logic [31:0] SKIP_BASE = 32'hbfc00380,
    parameter int          SKIP_LEN  = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LANES-1:0]          cm_valid,
    input  logic [LANES-1:0]          cm_wen,
    input  logic [LANES*5-1:0]        cm_rd,
    input  logic [LANES*DATA_W-1:0]   cm_wdata,
    input  logic [LANES*32-1:0]       cm_pc,
    output logic                      cm_stall,
    input  logic                      ref_valid,
    output logic                      ref_ready,
    input  logic [31:0]               ref_pc,
    input  logic [4:0]                ref_rd,
    input  logic [DATA_W-1:0]         ref_wdata,
    output logic                      err_valid,
    output logic [31:0]               err_pc,
    output logic [4:0]                err_rd,
    output logic [DATA_W-1:0]         err_wdata,
    output logic [15:0]               err_count,
    output logic [31:0]               inst_count,
    output logic                      overflow,
    output logic                      done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(LANES + 1);

`ifdef TRACE_CMP_SKIP_EN
    localparam logic SKIP_ON = 1'b1;
`else
    localparam logic SKIP_ON = 1'b0;
`endif

    function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    logic [31:0]       pc_mem_r   [DEPTH];
    logic [4:0]        rd_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [OCC_W-1:0]  occ_r, occ_next_s;
    logic              done_req_r;

    logic [LANES-1:0]  live_s;
    logic [LANES-1:0]  push_s;
    logic [PTR_W-1:0]  push_off_s [LANES];
    logic [CNT_W-1:0]  push_cnt_s;
    logic              end_hit_s;
    logic              pop_s;
    logic              mismatch_s;
    logic              skip_s;
    logic [31:0]       head_pc_s;
    logic [4:0]        head_rd_s;
    logic [DATA_W-1:0] head_data_s;

    assign cm_stall  = (OCC_W'(DEPTH) - occ_r) < OCC_W'(LANES);
    assign ref_ready = (occ_r != '0) && !done;
    assign pop_s     = ref_valid && ref_ready;

    assign head_pc_s   = pc_mem_r[rd_ptr_r];
    assign head_rd_s   = rd_mem_r[rd_ptr_r];
    assign head_data_s = data_mem_r[rd_ptr_r];

    // Lane qualification: lanes after the end-of-test commit are dead; survivors are compacted in lane order.
    always_comb begin
        live_s     = '0;
        push_s     = '0;
        push_cnt_s = '0;
        end_hit_s  = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            push_off_s[i] = PTR_W'(push_cnt_s);
            if (cm_valid[i] && !done_req_r && !end_hit_s) begin
                live_s[i] = 1'b1;
                if (cm_wen[i] && (cm_rd[i*5 +: 5] != 5'd0) && !cm_stall) begin
                    push_s[i]  = 1'b1;
                    push_cnt_s = push_cnt_s + CNT_W'(1);
                end else begin
                    push_s[i] = 1'b0;
                end
                if (cm_pc[i*32 +: 32] == END_PC) begin
                    end_hit_s = 1'b1;
                end else begin
                    end_hit_s = end_hit_s;
                end
            end else begin
                live_s[i] = 1'b0;
            end
        end
    end

    // Head comparison; the skip window is an unsigned distance test from SKIP_BASE.
    always_comb begin
        mismatch_s = (head_pc_s != ref_pc) || (head_rd_s != ref_rd) || (head_data_s != ref_wdata);
        skip_s     = SKIP_ON && ((head_pc_s - SKIP_BASE) < 32'(SKIP_LEN));
        occ_next_s = occ_r + OCC_W'(push_cnt_s) - OCC_W'(pop_s);
    end

    // Entry storage; stale contents are harmless because the pointers define validity.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (push_s[i]) begin
                pc_mem_r[wr_ptr_r + push_off_s[i]]   <= cm_pc[i*32 +: 32];
                rd_mem_r[wr_ptr_r + push_off_s[i]]   <= cm_rd[i*5 +: 5];
                data_mem_r[wr_ptr_r + push_off_s[i]] <= cm_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointers, counters, sticky flags and the registered error report.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            occ_r      <= '0;
            done_req_r <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            inst_count <= 32'd0;
            err_valid  <= 1'b0;
            err_pc     <= 32'd0;
            err_rd     <= 5'd0;
            err_wdata  <= '0;
            err_count  <= 16'd0;
        end else begin
            wr_ptr_r   <= wr_ptr_r + PTR_W'(push_cnt_s);
            occ_r      <= occ_next_s;
            inst_count <= inst_count + 32'(popcount(live_s));
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (end_hit_s) begin
                done_req_r <= 1'b1;
            end
            if (done_req_r && (occ_next_s == '0)) begin
                done <= 1'b1;
            end
            if ((|cm_valid) && cm_stall) begin
                overflow <= 1'b1;
            end
            err_valid <= pop_s && mismatch_s && !skip_s;
            if (pop_s && mismatch_s && !skip_s) begin
                err_pc    <= head_pc_s;
                err_rd    <= head_rd_s;
                err_wdata <= head_data_s;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_checker.sv
// Scoreboard bench for commit_trace_checker: a queue model predicts FIFO contents, handshakes and error reports.
module tb_commit_trace_checker;

    localparam int          LANES  = 2;
    localparam int          DEPTH  = 16;
    localparam int          DATA_W = 32;
    localparam logic [31:0] END_PC = 32'hbfc00100;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;

    typedef struct packed {
        logic v;
        ent_t e;
    } err_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic [LANES-1:0]        cm_valid = '0;
    logic [LANES-1:0]        cm_wen = '0;
    logic [LANES*5-1:0]      cm_rd = '0;
    logic [LANES*DATA_W-1:0] cm_wdata = '0;
    logic [LANES*32-1:0]     cm_pc = '0;
    logic                    cm_stall;
    logic                    ref_valid = 1'b0;
    logic                    ref_ready;
    logic [31:0]             ref_pc = 32'd0;
    logic [4:0]              ref_rd = 5'd0;
    logic [DATA_W-1:0]       ref_wdata = '0;
    logic                    err_valid;
    logic [31:0]             err_pc;
    logic [4:0]              err_rd;
    logic [DATA_W-1:0]       err_wdata;
    logic [15:0]             err_count;
    logic [31:0]             inst_count;
    logic                    overflow;
    logic                    done;

    ent_t mq[$];
    ent_t rq[$];
    err_t eq[$];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pops   = 0;
    bit          ref_en   = 1'b0;
    bit          auto_ref = 1'b1;
    bit          armed    = 1'b0;
    logic [31:0] m_inst   = 32'd0;
    logic [15:0] m_err    = 16'd0;
    bit          m_ovf    = 1'b0;
    bit          m_done   = 1'b0;
    bit          m_done_req = 1'b0;
    ent_t        m_eent   = '0;

    always #5 clock = ~clock;

    commit_trace_checker #(
        .LANES(LANES), .DEPTH(DEPTH), .DATA_W(DATA_W), .END_PC(END_PC),
        .SKIP_BASE(32'hbfc00380), .SKIP_LEN(8)
    ) dut (
        .clock(clock), .reset(reset),
        .cm_valid(cm_valid), .cm_wen(cm_wen), .cm_rd(cm_rd), .cm_wdata(cm_wdata), .cm_pc(cm_pc),
        .cm_stall(cm_stall),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc), .ref_rd(ref_rd), .ref_wdata(ref_wdata),
        .err_valid(err_valid), .err_pc(err_pc), .err_rd(err_rd), .err_wdata(err_wdata),
        .err_count(err_count), .inst_count(inst_count), .overflow(overflow), .done(done)
    );

    task automatic set_lane(input int l, input logic w, input logic [4:0] rd,
                            input logic [31:0] wd, input logic [31:0] pc);
        cm_valid[l]        = 1'b1;
        cm_wen[l]          = w;
        cm_rd[l*5 +: 5]    = rd;
        cm_wdata[l*32 +: 32] = wd;
        cm_pc[l*32 +: 32]  = pc;
    endtask

    // One clock: check handshake outputs, update the model, then check registered outputs after the edge.
    task automatic cycle();
        bit   exp_ready, exp_stall, mis, hit;
        ent_t h, e;
        err_t er;
        int   sz;
        ref_valid = ref_en && (rq.size() != 0);
        if (ref_valid) begin
            ref_pc    = rq[0].pc;
            ref_rd    = rq[0].rd;
            ref_wdata = rq[0].wd;
        end
        sz        = mq.size();
        exp_ready = (sz != 0) && !m_done;
        exp_stall = (DEPTH - sz) < LANES;
        if (armed) begin
            n_checks++;
            if (ref_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL ref_ready got %0b exp %0b at %0t", ref_ready, exp_ready, $time);
            end
            n_checks++;
            if (cm_stall !== exp_stall) begin
                n_fail++;
                $display("FAIL cm_stall got %0b exp %0b (occ %0d) at %0t", cm_stall, exp_stall, sz, $time);
            end
        end
        er = '0;
        if (reset) begin
            mq.delete();
            rq.delete();
            m_inst = 32'd0; m_err = 16'd0; m_ovf = 1'b0;
            m_done = 1'b0; m_done_req = 1'b0; m_eent = '0;
        end else begin
            if (ref_valid && exp_ready) begin
                h = mq.pop_front();
                void'(rq.pop_front());
                n_pops++;
                mis = (h.pc != ref_pc) || (h.rd != ref_rd) || (h.wd != ref_wdata);
`ifdef TRACE_CMP_SKIP_EN
                if ((h.pc - 32'hbfc00380) < 32'd8) mis = 1'b0;
`endif
                er.v = mis;
                er.e = h;
            end
            if (m_done_req && mq.size() == 0) m_done = 1'b1;
            if (!m_done_req) begin
                hit = 1'b0;
                for (int l = 0; l < LANES; l++) begin
                    if (cm_valid[l] && !hit) begin
                        m_inst = m_inst + 32'd1;
                        if (cm_wen[l] && cm_rd[l*5 +: 5] != 5'd0 && !exp_stall) begin
                            e = {cm_pc[l*32 +: 32], cm_rd[l*5 +: 5], cm_wdata[l*32 +: 32]};
                            mq.push_back(e);
                            if (auto_ref) rq.push_back(e);
                        end
                        if (cm_pc[l*32 +: 32] == END_PC) hit = 1'b1;
                    end
                end
                if (hit) m_done_req = 1'b1;
            end
            if ((|cm_valid) && exp_stall) m_ovf = 1'b1;
            if (er.v) begin
                if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                m_eent = er.e;
            end
        end
        eq.push_back(er);
        @(posedge clock);
        #1;
        cm_valid = '0;
        cm_wen   = '0;
        er = eq.pop_front();
        n_checks++;
        if (err_valid !== er.v) begin
            n_fail++;
            $display("FAIL err_valid got %0b exp %0b at %0t", err_valid, er.v, $time);
        end
        n_checks++;
        if (err_pc !== m_eent.pc || err_rd !== m_eent.rd || err_wdata !== m_eent.wd) begin
            n_fail++;
            $display("FAIL err_fields got %h/%0d/%h exp %h/%0d/%h", err_pc, err_rd, err_wdata,
                     m_eent.pc, m_eent.rd, m_eent.wd);
        end
        n_checks++;
        if (err_count !== m_err || inst_count !== m_inst) begin
            n_fail++;
            $display("FAIL counters got err %0d inst %0d exp err %0d inst %0d at %0t",
                     err_count, inst_count, m_err, m_inst, $time);
        end
        n_checks++;
        if (overflow !== m_ovf || done !== m_done) begin
            n_fail++;
            $display("FAIL flags got ovf %0b done %0b exp ovf %0b done %0b at %0t",
                     overflow, done, m_ovf, m_done, $time);
        end
        armed = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && mq.size() != 0; i++) cycle();
        n_checks++;
        if (mq.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout got %0d entries left exp 0", mq.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        n_checks++;
        if (ref_ready !== 1'b0 || cm_stall !== 1'b0 || err_valid !== 1'b0 || inst_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state got rdy %0b stall %0b err %0b inst %0d exp all 0",
                     ref_ready, cm_stall, err_valid, inst_count);
        end
    endtask

    task automatic test_stream();
        int p0;
        p0 = n_pops;
        ref_en = 1'b1;
        auto_ref = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_lane(0, 1'b1, 5'(2*k + 1), $urandom, 32'h1000 + 32'(8*k));
            set_lane(1, 1'b1, 5'(2*k + 2), $urandom, 32'h1004 + 32'(8*k));
            cycle();
        end
        drain(40);
        n_checks++;
        if (n_pops - p0 != 20 || inst_count !== 32'd20 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stream got pops %0d inst %0d err %0d exp 20/20/0", n_pops - p0, inst_count, err_count);
        end
    endtask

    task automatic test_rd_zero();
        int p0;
        p0 = n_pops;
        auto_ref = 1'b0;
        rq.push_back(ent_t'({32'h2004, 5'd3, 32'h5}));
        set_lane(0, 1'b1, 5'd0, 32'h77, 32'h2000);
        set_lane(1, 1'b1, 5'd3, 32'h5, 32'h2004);
        cycle();
        drain(10);
        cycle();
        n_checks++;
        if (n_pops - p0 != 1 || inst_count !== 32'd22 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL rd_zero got pops %0d inst %0d err %0d exp 1/22/0", n_pops - p0, inst_count, err_count);
        end
    endtask

    task automatic test_mismatch();
        auto_ref = 1'b0;
        rq.push_back(ent_t'({32'hbfc00010, 5'd7, 32'hDEADBEEF}));
        set_lane(0, 1'b1, 5'd7, 32'hDEADBEEE, 32'hbfc00010);
        cycle();
        drain(10);
        n_checks++;
        if (err_valid !== 1'b1 || err_pc !== 32'hbfc00010 || err_wdata !== 32'hDEADBEEE || err_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mismatch got v %0b pc %h data %h cnt %0d exp 1 bfc00010 deadbeee 1",
                     err_valid, err_pc, err_wdata, err_count);
        end
        cycle();
        n_checks++;
        if (err_valid !== 1'b0 || err_pc !== 32'hbfc00010) begin
            n_fail++;
            $display("FAIL err_hold got v %0b pc %h exp 0 bfc00010", err_valid, err_pc);
        end
    endtask

    task automatic test_skip();
        logic [15:0] exp_cnt;
`ifdef TRACE_CMP_SKIP_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd2;
`endif
        rq.push_back(ent_t'({32'hbfc00384, 5'd4, 32'h1111}));
        set_lane(0, 1'b1, 5'd4, 32'h2222, 32'hbfc00384);
        cycle();
        drain(10);
        cycle();
        n_checks++;
        if (err_count !== exp_cnt) begin
            n_fail++;
            $display("FAIL skip_window got err_count %0d exp %0d", err_count, exp_cnt);
        end
    endtask

    task automatic test_stall_overflow();
        ref_en = 1'b0;
        auto_ref = 1'b1;
        set_lane(0, 1'b1, 5'd1, 32'h100, 32'h3000);
        cycle();
        for (int k = 0; k < 7; k++) begin
            set_lane(0, 1'b1, 5'd2, 32'(k), 32'h3004 + 32'(8*k));
            set_lane(1, 1'b1, 5'd3, 32'(k), 32'h3008 + 32'(8*k));
            cycle();
        end
        n_checks++;
        if (cm_stall !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_at_15 got stall %0b ovf %0b exp 1 0", cm_stall, overflow);
        end
        set_lane(0, 1'b1, 5'd5, 32'h9, 32'h3100);
        set_lane(1, 1'b1, 5'd6, 32'h9, 32'h3104);
        cycle();
        n_checks++;
        if (overflow !== 1'b1 || cm_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow got ovf %0b stall %0b exp 1 1", overflow, cm_stall);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (overflow !== 1'b0 || cm_stall !== 1'b0 || ref_ready !== 1'b0 || inst_count !== 32'd0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid got ovf %0b stall %0b rdy %0b inst %0d err %0d exp all 0",
                     overflow, cm_stall, ref_ready, inst_count, err_count);
        end
    endtask

    task automatic test_end();
        int p0;
        ref_en = 1'b0;
        auto_ref = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 1'b1, 5'(10 + k), 32'hA0 + 32'(k), 32'h4000 + 32'(4*k));
            cycle();
        end
        set_lane(0, 1'b1, 5'd0, 32'h0, END_PC);
        set_lane(1, 1'b1, 5'd9, 32'h99, END_PC + 32'd4);
        cycle();
        set_lane(0, 1'b1, 5'd8, 32'h88, 32'h4100);
        cycle();
        p0 = n_pops;
        ref_en = 1'b1;
        drain(20);
        n_checks++;
        if (n_pops - p0 != 3 || done !== 1'b1 || ref_ready !== 1'b0 || inst_count !== 32'd4) begin
            n_fail++;
            $display("FAIL end_of_test got pops %0d done %0b rdy %0b inst %0d exp 3 1 0 4",
                     n_pops - p0, done, ref_ready, inst_count);
        end
        set_lane(0, 1'b1, 5'd8, 32'h88, 32'h4200);
        cycle();
        n_checks++;
        if (done !== 1'b1 || ref_ready !== 1'b0 || inst_count !== 32'd4) begin
            n_fail++;
            $display("FAIL after_done got done %0b rdy %0b inst %0d exp 1 0 4", done, ref_ready, inst_count);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_rd_zero();
        test_mismatch();
        test_skip();
        test_stall_overflow();
        test_reset_mid();
        test_end();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
